// File: rtl/count_event_fifo.sv
`default_nettype none
// ============================================================================
// Module   : count_event_fifo
// Purpose  : Watches an upstream x/y counter pair. Each change of x captures
//            the {x,y} pair as an event record into a small FIFO that is
//            drained through a valid/ready handshake. Records that arrive
//            while the FIFO is full are dropped and accounted for with a
//            sticky overflow flag and a saturating drop counter.
// Ports    : clk        - clock, rising-edge
//            rst        - asynchronous active-low reset
//            x, y       - upstream slow / fast counts, sampled every clock
//            out_valid  - head record available
//            out_ready  - consumer accepts head record
//            out_data   - head record {x,y}, x in upper W bits
//            level      - FIFO occupancy 0..DEPTH
//            ovf        - sticky: at least one record dropped
//            drop_cnt   - dropped-record count, saturating at 15
//            clr_ovf    - synchronous clear of ovf and drop_cnt
// Revision : 1.0 - initial release
// ============================================================================
module count_event_fifo #(
  parameter int W     = 4,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_data,
  output logic [AW:0]    level,
  output logic           ovf,
  output logic [3:0]     drop_cnt,
  input  logic           clr_ovf
);

  localparam logic [AW:0]   FULL_LEVEL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LVL_ONE    = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [3:0]    CNT_MAX    = 4'hF;

  logic [2*W-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic [W-1:0]  x_prev_q, x_prev_d;
  logic          armed_q, armed_d;
  logic          ovf_q, ovf_d;
  logic [3:0]    drop_cnt_q, drop_cnt_d;

  logic evt, pop, push, drop, full;

  always_comb begin
    evt  = armed_q && (x != x_prev_q);
    pop  = (level_q != '0) && out_ready;
    full = (level_q == FULL_LEVEL);
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    push = evt && (!full || pop);
    drop = evt && full && !pop;

    wr_ptr_d   = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d   = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    x_prev_d   = x;
    armed_d    = 1'b1;

    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase

    ovf_d      = ovf_q;
    drop_cnt_d = drop_cnt_q;
    // Clear takes priority over a drop on the same edge.
    if (clr_ovf) begin
      ovf_d      = 1'b0;
      drop_cnt_d = 4'h0;
    end else if (drop) begin
      ovf_d = 1'b1;
      if (drop_cnt_q != CNT_MAX) begin
        drop_cnt_d = drop_cnt_q + 4'h1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      x_prev_q   <= '0;
      armed_q    <= 1'b0;
      ovf_q      <= 1'b0;
      drop_cnt_q <= 4'h0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      x_prev_q   <= x_prev_d;
      armed_q    <= armed_d;
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {x, y};
    end
  end

  assign out_valid = (level_q != '0);
  // Gated so that an empty FIFO (including right after reset) presents zero.
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign level     = level_q;
  assign ovf       = ovf_q;
  assign drop_cnt  = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_count_event_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_count_event_fifo
// Purpose  : Directed self-checking bench for count_event_fifo. Expected
//            records are queued when the bench drives an x change and are
//            compared when the DUT hands them out.
// Revision : 1.0 - initial release
// ============================================================================
module tb_count_event_fifo;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] x, y;
  logic       out_valid, out_ready, ovf, clr_ovf;
  logic [7:0] out_data;
  logic [2:0] level;
  logic [3:0] drop_cnt;

  always #5 clk = ~clk;

  count_event_fifo #(.W(4), .DEPTH(DEPTH), .AW(2)) dut (
    .clk(clk), .rst(rst), .x(x), .y(y),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level), .ovf(ovf), .drop_cnt(drop_cnt), .clr_ovf(clr_ovf)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] sb[$];
  logic       m_armed;
  logic [3:0] m_xprev;
  logic       m_ovf;
  logic [3:0] m_cnt;
  logic       popped_flag;
  logic [7:0] popped_dut;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_armed = 1'b0;
    m_xprev = 4'h0;
    m_ovf   = 1'b0;
    m_cnt   = 4'h0;
  endtask

  // One clock: predict the edge from current inputs, clock, then compare.
  task automatic step();
    logic mpop, ev;
    logic [7:0] exp_head;
    mpop = (sb.size() > 0) && out_ready;
    popped_flag = 1'b0;
    if (mpop) begin
      exp_head    = sb.pop_front();
      popped_dut  = out_data;
      popped_flag = 1'b1;
      chk("pop_data", 16'(out_data), 16'(exp_head));
    end
    ev = m_armed && (x != m_xprev);
    m_xprev = x;
    m_armed = 1'b1;
    if (ev) begin
      if (sb.size() < DEPTH) sb.push_back({x, y});
      else if (!clr_ovf) begin
        m_ovf = 1'b1;
        if (m_cnt != 4'hF) m_cnt = m_cnt + 4'h1;
      end
    end
    if (clr_ovf) begin
      m_ovf = 1'b0;
      m_cnt = 4'h0;
    end
    @(posedge clk);
    #1;
    chk("level", 16'(level), 16'(sb.size()));
    chk("out_valid", 16'(out_valid), 16'(sb.size() != 0));
    chk("ovf", 16'(ovf), 16'(m_ovf));
    chk("drop_cnt", 16'(drop_cnt), 16'(m_cnt));
    if (sb.size() != 0) chk("head", 16'(out_data), 16'(sb[0]));
  endtask

  initial begin
    logic [3:0] xs [4];
    logic [3:0] ys [4];
    logic [7:0] drain_exp [4];
    logic [3:0] x_s, y_s, last_x;
    logic       have_last;
    int         nrec;

    xs = '{4'hE, 4'hF, 4'h0, 4'h1};
    ys = '{4'h3, 4'h4, 4'h5, 4'h6};
    drain_exp = '{8'hE3, 8'hF4, 8'h05, 8'h16};

    // ---- 1: reset state and arming ----
    rst = 1'b0; x = 4'h5; y = 4'h0; out_ready = 1'b0; clr_ovf = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 16'(out_valid), 16'h0);
    chk("rst_level", 16'(level), 16'h0);
    chk("rst_ovf", 16'(ovf), 16'h0);
    chk("rst_drop", 16'(drop_cnt), 16'h0);
    chk("rst_data", 16'(out_data), 16'h0);
    rst = 1'b1;
    repeat (3) step();
    chk("arm_no_event", 16'(level), 16'h0);
    x = 4'h6; y = 4'h9;
    step();
    chk("arm_valid", 16'(out_valid), 16'h1);
    chk("arm_data", 16'(out_data), 16'h69);
    chk("arm_level", 16'(level), 16'h1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // ---- 2: wrap of x, fill to full ----
    for (int i = 0; i < 4; i++) begin
      x = xs[i]; y = ys[i];
      step();
    end
    chk("full_level", 16'(level), 16'h4);

    // ---- 3: overflow, saturation, clear beating a same-edge drop ----
    for (int i = 0; i < 3; i++) begin
      x = x + 4'h1;
      step();
    end
    chk("ovf_set", 16'(ovf), 16'h1);
    chk("drop3", 16'(drop_cnt), 16'h3);
    chk("ovf_level", 16'(level), 16'h4);
    for (int i = 0; i < 13; i++) begin
      x = x + 4'h1;
      step();
    end
    chk("drop_sat", 16'(drop_cnt), 16'hF);
    clr_ovf = 1'b1; x = x + 4'h1;
    step();
    clr_ovf = 1'b0;
    chk("clr_ovf", 16'(ovf), 16'h0);
    chk("clr_drop", 16'(drop_cnt), 16'h0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_order", 16'(out_data), 16'(drain_exp[i]));
      step();
    end
    chk("drain_empty", 16'(out_valid), 16'h0);

    // ---- 4: full with simultaneous push and pop ----
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      x = x + 4'h1; y = 4'(i);
      step();
    end
    out_ready = 1'b1; x = 4'h7; y = 4'hA;
    step();
    chk("pp_level", 16'(level), 16'h4);
    chk("pp_drop", 16'(drop_cnt), 16'h0);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) chk("pp_tail", 16'(out_data), 16'h7A);
      step();
    end

    // ---- 5: reset mid-operation ----
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      x = x + 4'h1; y = 4'h1;
      step();
    end
    chk("pre_rst_level", 16'(level), 16'h3);
    rst = 1'b0;
    #2;
    chk("midrst_valid", 16'(out_valid), 16'h0);
    chk("midrst_level", 16'(level), 16'h0);
    model_reset();
    #2;
    rst = 1'b1;
    x = x + 4'h5;
    step();
    chk("rearm_no_event", 16'(level), 16'h0);
    x = x + 4'h1; y = 4'h2;
    step();
    chk("rearm_first", 16'(level), 16'h1);
    chk("rearm_data", 16'(out_data), 16'({x, 4'h2}));
    out_ready = 1'b1;
    step();

    // ---- 6: upstream counter integration (y counts 0..14, x bumps after y%3==0) ----
    rst = 1'b0; x = 4'h0; y = 4'h1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    have_last = 1'b0; last_x = 4'h0; nrec = 0;
    for (int i = 0; i < 48; i++) begin
      x_s = x; y_s = y;
      step();
      if (popped_flag) begin
        nrec++;
        chk("y_mod3", 16'(popped_dut[3:0] % 4'd3), 16'h1);
        if (have_last) chk("x_consec", 16'(popped_dut[7:4]), 16'(last_x + 4'h1));
        last_x = popped_dut[7:4];
        have_last = 1'b1;
      end
      if (y_s % 4'd3 == 4'd0) x = x_s + 4'h1;
      y = (y_s == 4'hE) ? 4'h0 : y_s + 4'h1;
    end
    chk("int_records", 16'(nrec >= 12), 16'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
